// File: rtl/sync_fifo_pkg.sv
// Shared constants and helpers for the parametrised synchronous FIFO.
package sync_fifo_pkg;

    localparam int unsigned FIFO_MODE_REG  = 0;
    localparam int unsigned FIFO_MODE_FWFT = 1;

    localparam int unsigned DEFAULT_WIDTH = 30;
    localparam int unsigned DEFAULT_DEPTH = 8;

    // Ceiling log2, usable in parameter expressions.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        while ((32'd1 << result) < value) begin
            result++;
        end
        return result;
    endfunction

endpackage

// File: rtl/fifo_mem_2p.sv
// WIDTH x DEPTH register array: synchronous write port, asynchronous read port.
module fifo_mem_2p
    import sync_fifo_pkg::*;
#(
    parameter int unsigned WIDTH = DEFAULT_WIDTH,
    parameter int unsigned DEPTH = DEFAULT_DEPTH,
    parameter int unsigned AW    = clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [WIDTH-1:0] wr_data,
    input  logic [AW-1:0]    rd_addr,
    output logic [WIDTH-1:0] rd_data
);

    logic [WIDTH-1:0] mem [DEPTH];

    // Storage is intentionally not reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/sync_fifo_param.sv
// Single-clock FIFO with fill count, almost flags, sticky error flags, flush and FWFT option.
module sync_fifo_param
    import sync_fifo_pkg::*;
#(
    parameter int unsigned WIDTH     = DEFAULT_WIDTH,
    parameter int unsigned DEPTH     = DEFAULT_DEPTH,
    parameter int unsigned AF_THRESH = 7,
    parameter int unsigned AE_THRESH = 1,
    parameter int unsigned FWFT      = FIFO_MODE_REG,
    localparam int unsigned AW       = clog2(DEPTH),
    localparam int unsigned CW       = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             wr,
    input  logic             rd,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] data_out,
    output logic             full,
    output logic             empty,
    output logic             almost_full,
    output logic             almost_empty,
    output logic [CW-1:0]    count,
    output logic             overflow,
    output logic             underflow
);

    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;
    logic [WIDTH-1:0] mem_rd_data;

    assign wr_en = wr & ~full;
    assign rd_en = rd & ~empty;

    assign full         = (count == CW'(DEPTH));
    assign empty        = (count == '0);
    assign almost_full  = (count >= CW'(AF_THRESH));
    assign almost_empty = (count <= CW'(AE_THRESH));

    fifo_mem_2p #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk     (clk),
        .wr_en   (wr_en & ~clr),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_addr (rd_ptr),
        .rd_data (mem_rd_data)
    );

    // Flush takes priority over any access in the same cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else if (clr) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en && !rd_en) begin
                count <= count + 1'b1;
            end else if (rd_en && !wr_en) begin
                count <= count - 1'b1;
            end
            if (wr && full) begin
                overflow <= 1'b1;
            end
            if (rd && empty) begin
                underflow <= 1'b1;
            end
        end
    end

    if (FWFT == FIFO_MODE_FWFT) begin : g_fwft
        // Head word is shown directly; rd only pops it.
        assign data_out = empty ? '0 : mem_rd_data;
    end else begin : g_reg
        logic [WIDTH-1:0] dout_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                dout_q <= '0;
            end else if (clr) begin
                dout_q <= '0;
            end else if (rd_en) begin
                dout_q <= mem_rd_data;
            end
        end

        assign data_out = dout_q;
    end

endmodule

// File: tb/tb_sync_fifo_param.sv
// Scoreboard bench for sync_fifo_param: registered-read instance plus an FWFT instance.
module tb_sync_fifo_param;

    localparam int unsigned WIDTH = 30;
    localparam int unsigned DEPTH = 8;
    localparam int unsigned AF    = 7;
    localparam int unsigned AE    = 1;
    localparam int unsigned CW    = 4;

    logic             clk = 1'b0;
    logic             rst;
    logic             clr;
    logic             wr;
    logic             rd;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] data_out;
    logic             full, empty, almost_full, almost_empty, overflow, underflow;
    logic [CW-1:0]    count;

    logic             wr_f;
    logic             rd_f;
    logic [WIDTH-1:0] data_in_f;
    logic [WIDTH-1:0] data_out_f;
    logic             full_f, empty_f, almost_full_f, almost_empty_f, overflow_f, underflow_f;
    logic [CW-1:0]    count_f;

    int n_cmp = 0;
    int n_bad = 0;

    logic [WIDTH-1:0] sb_q [$];
    logic [WIDTH-1:0] fwft_q [$];
    logic             m_ovf;
    logic             m_udf;
    logic [WIDTH-1:0] m_dout;

    always #5 clk = ~clk;

    sync_fifo_param #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF),
        .AE_THRESH (AE),
        .FWFT      (0)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .clr          (clr),
        .wr           (wr),
        .rd           (rd),
        .data_in      (data_in),
        .data_out     (data_out),
        .full         (full),
        .empty        (empty),
        .almost_full  (almost_full),
        .almost_empty (almost_empty),
        .count        (count),
        .overflow     (overflow),
        .underflow    (underflow)
    );

    sync_fifo_param #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .AF_THRESH (AF),
        .AE_THRESH (AE),
        .FWFT      (1)
    ) u_dut_fwft (
        .clk          (clk),
        .rst          (rst),
        .clr          (clr),
        .wr           (wr_f),
        .rd           (rd_f),
        .data_in      (data_in_f),
        .data_out     (data_out_f),
        .full         (full_f),
        .empty        (empty_f),
        .almost_full  (almost_full_f),
        .almost_empty (almost_empty_f),
        .count        (count_f),
        .overflow     (overflow_f),
        .underflow    (underflow_f)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check_eq({tag, ".count"}, 32'(count), 32'(sb_q.size()));
        check_eq({tag, ".full"}, 32'(full), 32'(sb_q.size() == DEPTH));
        check_eq({tag, ".empty"}, 32'(empty), 32'(sb_q.size() == 0));
        check_eq({tag, ".almost_full"}, 32'(almost_full), 32'(sb_q.size() >= AF));
        check_eq({tag, ".almost_empty"}, 32'(almost_empty), 32'(sb_q.size() <= AE));
        check_eq({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
        check_eq({tag, ".underflow"}, 32'(underflow), 32'(m_udf));
        check_eq({tag, ".data_out"}, 32'(data_out), 32'(m_dout));
    endtask

    task automatic model_reset();
        sb_q.delete();
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        m_dout = '0;
    endtask

    // One clock of stimulus on the registered instance, model updated from pre-edge state.
    task automatic step(input string tag, input logic w, input logic r, input logic c,
                        input logic [WIDTH-1:0] d);
        logic wa, ra;
        @(negedge clk);
        wr      = w;
        rd      = r;
        clr     = c;
        data_in = d;
        if (c) begin
            model_reset();
        end else begin
            wa = w && (sb_q.size() != DEPTH);
            ra = r && (sb_q.size() != 0);
            if (w && !wa) m_ovf = 1'b1;
            if (r && !ra) m_udf = 1'b1;
            if (ra) m_dout = sb_q.pop_front();
            if (wa) sb_q.push_back(d);
        end
        @(posedge clk);
        #1;
        wr  = 1'b0;
        rd  = 1'b0;
        clr = 1'b0;
        check_state(tag);
    endtask

    initial begin
        logic [WIDTH-1:0] fill_v [8];
        fill_v = '{30'd512, 30'd2222, 30'd312, 30'd404, 30'd5, 30'd6, 30'd7, 30'd8};

        rst = 1'b1; clr = 1'b0; wr = 1'b0; rd = 1'b0; data_in = '0;
        wr_f = 1'b0; rd_f = 1'b0; data_in_f = '0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_state("reset0");

        // Asynchronous reset between edges after partial fill and one read
        step("pre_w0", 1'b1, 1'b0, 1'b0, 30'd11);
        step("pre_w1", 1'b1, 1'b0, 1'b0, 30'd22);
        step("pre_w2", 1'b1, 1'b0, 1'b0, 30'd33);
        step("pre_r0", 1'b0, 1'b1, 1'b0, 30'd0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        model_reset();
        check_state("async_rst");
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 8; i++) step("fill", 1'b1, 1'b0, 1'b0, fill_v[i]);
        step("fill_over", 1'b1, 1'b0, 1'b0, 30'd9);
        for (int i = 0; i < 8; i++) step("drain", 1'b0, 1'b1, 1'b0, 30'd0);
        step("drain_under", 1'b0, 1'b1, 1'b0, 30'd0);
        step("clr_flags", 1'b0, 1'b0, 1'b1, 30'd0);

        // Simultaneous read/write mid-fill, at full and at empty
        for (int i = 0; i < 4; i++) step("sim_pre", 1'b1, 1'b0, 1'b0, 30'(100 + i));
        step("sim_mid", 1'b1, 1'b1, 1'b0, 30'd104);
        for (int i = 0; i < 4; i++) step("sim_top", 1'b1, 1'b0, 1'b0, 30'(105 + i));
        step("sim_full", 1'b1, 1'b1, 1'b0, 30'd200);
        for (int i = 0; i < 7; i++) step("sim_drain", 1'b0, 1'b1, 1'b0, 30'd0);
        step("sim_empty", 1'b1, 1'b1, 1'b0, 30'd300);
        step("sim_last", 1'b0, 1'b1, 1'b0, 30'd0);
        step("clr_sim", 1'b0, 1'b0, 1'b1, 30'd0);

        // Pointer wrap
        for (int i = 0; i < 5; i++) step("wrap_w5", 1'b1, 1'b0, 1'b0, 30'(20 + i));
        for (int i = 0; i < 5; i++) step("wrap_r5", 1'b0, 1'b1, 1'b0, 30'd0);
        for (int i = 0; i < 6; i++) step("wrap_w6", 1'b1, 1'b0, 1'b0, 30'(10 + i));
        for (int i = 0; i < 6; i++) step("wrap_r6", 1'b0, 1'b1, 1'b0, 30'd0);

        // Flush with a concurrent write; the write must be dropped
        for (int i = 0; i < 3; i++) step("flush_w", 1'b1, 1'b0, 1'b0, 30'(40 + i));
        step("flush_clr_wr", 1'b1, 1'b0, 1'b1, 30'd99);
        step("post_flush_w", 1'b1, 1'b0, 1'b0, 30'd50);
        step("post_flush_r", 1'b0, 1'b1, 1'b0, 30'd0);

        // FWFT instance: word shows up after the write edge, rd pops it
        @(negedge clk);
        wr_f      = 1'b1;
        data_in_f = 30'd512;
        #1;
        check_eq("fwft.no_through", 32'(data_out_f), 32'd0);
        @(posedge clk);
        #1;
        wr_f = 1'b0;
        fwft_q.push_back(30'd512);
        check_eq("fwft.head", 32'(data_out_f), 32'(fwft_q[0]));
        check_eq("fwft.empty1", 32'(empty_f), 32'd0);
        check_eq("fwft.count1", 32'(count_f), 32'(fwft_q.size()));
        @(negedge clk);
        check_eq("fwft.hold", 32'(data_out_f), 32'(fwft_q[0]));
        rd_f = 1'b1;
        @(posedge clk);
        #1;
        rd_f = 1'b0;
        void'(fwft_q.pop_front());
        check_eq("fwft.popped", 32'(data_out_f), 32'd0);
        check_eq("fwft.empty2", 32'(empty_f), 32'(fwft_q.size() == 0));
        check_eq("fwft.underflow", 32'(underflow_f), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Parametrised next-generation synchronous FIFO: one clock domain, configurable data width and depth, registered or first-word-fall-through (FWFT) read mode. Adds fill count, programmable almost-full/almost-empty flags, sticky overflow/underflow error flags and a synchronous flush. Drop-in buffer between producer and consumer datapaths in the same clock domain.

Parameters:
WIDTH, 30, data word width in bits (>=1)
DEPTH, 8, number of entries; power of two, >=2
AF_THRESH, 7, almost_full asserts when count >= AF_THRESH (1..DEPTH)
AE_THRESH, 1, almost_empty asserts when count <= AE_THRESH (0..DEPTH-1)
FWFT, 0, 0 = registered read (data one cycle after rd); 1 = first-word-fall-through

Ports:
clk  in  1  single clock, rising edge
rst  in  1  asynchronous reset, active-high
clr  in  1  synchronous flush
wr  in  1  write request
rd  in  1  read request
data_in  in  WIDTH  write data
data_out  out  WIDTH  read data
full  out  1  count == DEPTH
empty  out  1  count == 0
almost_full  out  1  count >= AF_THRESH
almost_empty  out  1  count <= AE_THRESH
count  out  clog2(DEPTH)+1  current fill level, 0..DEPTH
overflow  out  1  sticky: write rejected since last rst/clr
underflow  out  1  sticky: read rejected since last rst/clr

Behaviour:
- Interface fixed: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset (async, immediate): wr_ptr=rd_ptr=0, count=0, empty=1, full=0, almost_empty=1, almost_full=0, overflow=underflow=0, data_out=0. Memory contents not reset.
- Acceptance: wr_en = wr & ~full; rd_en = rd & ~empty; both evaluated on pre-edge state.
- Write: on wr_en, mem[wr_ptr] <= data_in, wr_ptr++ (wraps DEPTH-1 -> 0).
- Read: on rd_en, rd_ptr++ (wraps). FWFT=0: data_out <= mem[rd_ptr] at the same edge, i.e. valid the cycle after rd; holds last value when no read. FWFT=1: data_out = mem[rd_ptr] combinationally while ~empty, 0 while empty; rd acknowledges/pops the displayed word.
- count: +1 on wr_en only, -1 on rd_en only, unchanged on both/neither. All flags combinational from registered count.
- Simultaneous wr&rd: mid-fill -> both accepted, count unchanged. At full -> read accepted, write rejected, overflow set. At empty -> write accepted, read rejected, underflow set (no read-through; in FWFT=1 the word appears the next cycle).
- overflow sets on wr & full; underflow sets on rd & empty; both sticky until rst or clr.
- clr (synchronous, priority over wr/rd same cycle): pointers, count, overflow, underflow -> 0; wr/rd that cycle ignored; FWFT=0 data_out -> 0.
- rst asserted mid-operation aborts any in-flight access; state as reset regardless of clk.
- No combinational path from data_in to data_out in either mode.

Decomposition:
- Package sync_fifo_pkg: clog2 constant function, FWFT mode constants (FIFO_MODE_REG=0, FIFO_MODE_FWFT=1), default WIDTH/DEPTH.
- Sub-module fifo_mem_2p: WIDTH x DEPTH register array, synchronous write port, asynchronous read port. Pointers, count, flags and output register live in sync_fifo_param.

Test Plan:
- Reset: drive rst=1 between clock edges after filling 3 words -> immediately count=0, empty=1, full=0, almost_empty=1, overflow=underflow=0, data_out=0.
- Fill (WIDTH=30, DEPTH=8, FWFT=0): write 512,2222,312,404,5,6,7,8 -> count 1..8, almost_full at count 7, full at 8. A 9th write of 9 -> rejected, count=8, overflow=1.
- Drain: 8 reads -> data_out 512,2222,312,404,5,6,7,8, each one cycle after its rd. empty after the 8th read. A 9th rd -> underflow=1, data_out holds 8.
- Simultaneous: at count=4, wr+rd -> count stays 4, FIFO order preserved. At full, wr+rd -> count=7, overflow=1. At empty, wr+rd -> count=1, underflow=1.
- Wrap and flush: write 5, read 5, write 6 (values 10..15), read 6 -> 10..15 in order across pointer wrap. Then write 3, assert clr with wr=1 -> count=0, empty=1, flags 0, the clr-cycle write discarded.
- FWFT=1 instance: write 512 into empty -> next cycle data_out=512 with no rd. rd -> data_out=0, empty=1.
